// File: rtl/dma_arb_pkg.sv
// Shared types and helpers for the DMA descriptor arbiter.
package dma_arb_pkg;

    localparam int unsigned STATUS_ERR_WIDTH = 4;

    // Widths of the default descriptor build, used by the desc_t payload type.
    localparam int unsigned DESC_PCIE_ADDR_WIDTH = 64;
    localparam int unsigned DESC_AXI_ADDR_WIDTH  = 48;
    localparam int unsigned DESC_LEN_WIDTH       = 16;
    localparam int unsigned DESC_TAG_WIDTH       = 8;

    typedef struct packed {
        logic [DESC_PCIE_ADDR_WIDTH-1:0] pcie_addr;
        logic [DESC_AXI_ADDR_WIDTH-1:0]  axi_addr;
        logic [DESC_LEN_WIDTH-1:0]       len;
        logic [DESC_TAG_WIDTH-1:0]       tag;
    } desc_t;

    // Bits needed to hold a port index (at least one).
    function automatic int unsigned port_idx_width(input int unsigned ports);
        return (ports > 1) ? int'($clog2(ports)) : 1;
    endfunction

endpackage

// File: rtl/dma_desc_arbiter_if.sv
// Descriptor/status bus bundle for dma_desc_arbiter; slave = arbiter side.
interface dma_desc_arbiter_if
    import dma_arb_pkg::*;
#(
    parameter int unsigned PORTS           = 4,
    parameter int unsigned PCIE_ADDR_WIDTH = 64,
    parameter int unsigned AXI_ADDR_WIDTH  = 48,
    parameter int unsigned LEN_WIDTH       = 16,
    parameter int unsigned TAG_WIDTH       = 8,
    parameter int unsigned S_TAG_WIDTH     = TAG_WIDTH - $clog2(PORTS)
);
    logic [PORTS*PCIE_ADDR_WIDTH-1:0]  s_desc_pcie_addr;
    logic [PORTS*AXI_ADDR_WIDTH-1:0]   s_desc_axi_addr;
    logic [PORTS*LEN_WIDTH-1:0]        s_desc_len;
    logic [PORTS*S_TAG_WIDTH-1:0]      s_desc_tag;
    logic [PORTS-1:0]                  s_desc_valid;
    logic [PORTS-1:0]                  s_desc_ready;

    logic [PCIE_ADDR_WIDTH-1:0]        m_desc_pcie_addr;
    logic [AXI_ADDR_WIDTH-1:0]         m_desc_axi_addr;
    logic [LEN_WIDTH-1:0]              m_desc_len;
    logic [TAG_WIDTH-1:0]              m_desc_tag;
    logic                              m_desc_valid;
    logic                              m_desc_ready;

    logic [TAG_WIDTH-1:0]              s_status_tag;
    logic [STATUS_ERR_WIDTH-1:0]       s_status_error;
    logic                              s_status_valid;

    logic [PORTS*S_TAG_WIDTH-1:0]      m_status_tag;
    logic [PORTS*STATUS_ERR_WIDTH-1:0] m_status_error;
    logic [PORTS-1:0]                  m_status_valid;
    logic                              status_unroutable;

    modport slave (
        input  s_desc_pcie_addr, s_desc_axi_addr, s_desc_len, s_desc_tag, s_desc_valid,
        output s_desc_ready,
        output m_desc_pcie_addr, m_desc_axi_addr, m_desc_len, m_desc_tag, m_desc_valid,
        input  m_desc_ready,
        input  s_status_tag, s_status_error, s_status_valid,
        output m_status_tag, m_status_error, m_status_valid, status_unroutable
    );

    modport master (
        output s_desc_pcie_addr, s_desc_axi_addr, s_desc_len, s_desc_tag, s_desc_valid,
        input  s_desc_ready,
        input  m_desc_pcie_addr, m_desc_axi_addr, m_desc_len, m_desc_tag, m_desc_valid,
        output m_desc_ready,
        output s_status_tag, s_status_error, s_status_valid,
        input  m_status_tag, m_status_error, m_status_valid, status_unroutable
    );

endinterface

// File: rtl/dma_desc_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr, with wrap.
module rr_arbiter
    import dma_arb_pkg::*;
#(
    parameter  int unsigned PORTS = 4,
    localparam int unsigned IDX_W = port_idx_width(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [PORTS-1:0] grant_c,
    output logic [IDX_W-1:0] grant_idx_c,
    output logic             grant_any_c
);

    // Scan ports in priority order starting at ptr and take the first requester.
    always_comb begin
        int unsigned p;
        grant_c     = '0;
        grant_idx_c = '0;
        grant_any_c = 1'b0;
        p           = 0;
        for (int unsigned k = 0; k < PORTS; k++) begin
            p = 32'(ptr) + k;
            if (p >= PORTS) p = p - PORTS;
            if (!grant_any_c && req[p]) begin
                grant_c[p]  = 1'b1;
                grant_idx_c = IDX_W'(p);
                grant_any_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_desc_arbiter.sv
// Shares one DMA descriptor channel among PORTS requesters and routes
// completion status back by tag index. Optional per-port outstanding
// limit is built when DMA_ARB_LIMIT_EN is defined.
module dma_desc_arbiter
    import dma_arb_pkg::*;
#(
    parameter int unsigned PORTS           = 4,
    parameter int unsigned PCIE_ADDR_WIDTH = 64,
    parameter int unsigned AXI_ADDR_WIDTH  = 48,
    parameter int unsigned LEN_WIDTH       = 16,
    parameter int unsigned TAG_WIDTH       = 8,
    parameter int unsigned S_TAG_WIDTH     = TAG_WIDTH - $clog2(PORTS),
    parameter int unsigned MAX_OUTSTANDING = 16
) (
    input  logic              clk,
    input  logic              rst,
    dma_desc_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = port_idx_width(PORTS);
    localparam int unsigned ERR_W = STATUS_ERR_WIDTH;

    // Reject parameter sets the tag layout cannot represent.
    if (PORTS < 2 || PORTS > 16 || MAX_OUTSTANDING < 1 || S_TAG_WIDTH + IDX_W != TAG_WIDTH) begin : g_cfg_check
        $error("dma_desc_arbiter: unsupported parameter set");
    end

    logic [IDX_W-1:0]           rr_ptr;
    logic [PORTS-1:0]           credit_ok;
    logic [PORTS-1:0]           grant_c;
    logic [IDX_W-1:0]           grant_idx_c;
    logic                       grant_any_c;
    logic                       slot_free_c;
    logic                       accept_c;
    logic [PCIE_ADDR_WIDTH-1:0] sel_pcie_addr_c;
    logic [AXI_ADDR_WIDTH-1:0]  sel_axi_addr_c;
    logic [LEN_WIDTH-1:0]       sel_len_c;
    logic [S_TAG_WIDTH-1:0]     sel_tag_c;
    logic [IDX_W-1:0]           st_port_c;
    logic                       st_routable_c;

    rr_arbiter #(.PORTS(PORTS)) u_rr (
        .req         (bus.s_desc_valid & credit_ok),
        .ptr         (rr_ptr),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c),
        .grant_any_c (grant_any_c)
    );

    assign slot_free_c      = !bus.m_desc_valid || bus.m_desc_ready;
    assign accept_c         = grant_any_c && slot_free_c;
    assign bus.s_desc_ready = grant_c & {PORTS{slot_free_c}};
    assign st_port_c        = bus.s_status_tag[TAG_WIDTH-1:S_TAG_WIDTH];
    assign st_routable_c    = bus.s_status_valid && (32'(st_port_c) < PORTS);

    // One-hot mux of the granted port's descriptor fields.
    always_comb begin
        sel_pcie_addr_c = '0;
        sel_axi_addr_c  = '0;
        sel_len_c       = '0;
        sel_tag_c       = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            if (grant_c[i]) begin
                sel_pcie_addr_c = bus.s_desc_pcie_addr[i*PCIE_ADDR_WIDTH +: PCIE_ADDR_WIDTH];
                sel_axi_addr_c  = bus.s_desc_axi_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                sel_len_c       = bus.s_desc_len[i*LEN_WIDTH +: LEN_WIDTH];
                sel_tag_c       = bus.s_desc_tag[i*S_TAG_WIDTH +: S_TAG_WIDTH];
            end
        end
    end

    // Output slot: load on accept, empty when drained with nothing new.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.m_desc_valid     <= 1'b0;
            bus.m_desc_pcie_addr <= '0;
            bus.m_desc_axi_addr  <= '0;
            bus.m_desc_len       <= '0;
            bus.m_desc_tag       <= '0;
        end else if (accept_c) begin
            bus.m_desc_valid     <= 1'b1;
            bus.m_desc_pcie_addr <= sel_pcie_addr_c;
            bus.m_desc_axi_addr  <= sel_axi_addr_c;
            bus.m_desc_len       <= sel_len_c;
            bus.m_desc_tag       <= TAG_WIDTH'({grant_idx_c, sel_tag_c});
        end else if (bus.m_desc_ready) begin
            bus.m_desc_valid     <= 1'b0;
        end
    end

    // Round-robin pointer moves just past the port that was accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept_c) begin
            rr_ptr <= (32'(grant_idx_c) == PORTS - 1) ? '0 : grant_idx_c + 1'b1;
        end
    end

    // Status steering: one registered pulse on the owning port, or an unroutable flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.m_status_valid    <= '0;
            bus.m_status_tag      <= '0;
            bus.m_status_error    <= '0;
            bus.status_unroutable <= 1'b0;
        end else begin
            bus.m_status_valid    <= '0;
            bus.status_unroutable <= bus.s_status_valid && !st_routable_c;
            for (int unsigned i = 0; i < PORTS; i++) begin
                if (st_routable_c && st_port_c == IDX_W'(i)) begin
                    bus.m_status_valid[i]                          <= 1'b1;
                    bus.m_status_tag[i*S_TAG_WIDTH +: S_TAG_WIDTH] <= bus.s_status_tag[S_TAG_WIDTH-1:0];
                    bus.m_status_error[i*ERR_W +: ERR_W]           <= bus.s_status_error;
                end
            end
        end
    end

`ifdef DMA_ARB_LIMIT_EN
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0] out_cnt [PORTS];
    logic [PORTS-1:0] cnt_inc_c;
    logic [PORTS-1:0] cnt_dec_c;

    // Per-port in-flight accounting: accepts add, routed statuses retire.
    always_comb begin
        cnt_inc_c = grant_c & {PORTS{accept_c}};
        cnt_dec_c = '0;
        credit_ok = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            cnt_dec_c[i] = st_routable_c && (st_port_c == IDX_W'(i));
            credit_ok[i] = out_cnt[i] < CNT_W'(MAX_OUTSTANDING);
        end
    end

    // Counters saturate at zero; a simultaneous accept and retire cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < PORTS; i++) out_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                if (cnt_inc_c[i] && !cnt_dec_c[i]) begin
                    out_cnt[i] <= out_cnt[i] + 1'b1;
                end else if (cnt_dec_c[i] && !cnt_inc_c[i] && out_cnt[i] != '0) begin
                    out_cnt[i] <= out_cnt[i] - 1'b1;
                end
            end
        end
    end
`else
    // Limit not built: every valid requester is eligible.
    assign credit_ok = '1;
`endif

endmodule

// File: tb/tb_dma_desc_arbiter.sv
// Self-checking bench for dma_desc_arbiter (also covers DMA_ARB_LIMIT_EN builds).
module tb_dma_desc_arbiter;
    import dma_arb_pkg::*;

    localparam int unsigned PORTS = 4;
    localparam int unsigned PA_W  = 64;
    localparam int unsigned AA_W  = 48;
    localparam int unsigned LEN_W = 16;
    localparam int unsigned TAG_W = 8;
    localparam int unsigned ST_W  = 6;
    localparam int unsigned ERR_W = STATUS_ERR_WIDTH;
    localparam int          MAXO  = 2;
`ifdef DMA_ARB_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    dma_desc_arbiter_if #(.PORTS(PORTS), .PCIE_ADDR_WIDTH(PA_W), .AXI_ADDR_WIDTH(AA_W),
                          .LEN_WIDTH(LEN_W), .TAG_WIDTH(TAG_W), .S_TAG_WIDTH(ST_W)) bus ();
    dma_desc_arbiter_if #(.PORTS(3), .PCIE_ADDR_WIDTH(PA_W), .AXI_ADDR_WIDTH(AA_W),
                          .LEN_WIDTH(LEN_W), .TAG_WIDTH(TAG_W), .S_TAG_WIDTH(ST_W)) bus3 ();

    dma_desc_arbiter #(.PORTS(PORTS), .PCIE_ADDR_WIDTH(PA_W), .AXI_ADDR_WIDTH(AA_W),
                       .LEN_WIDTH(LEN_W), .TAG_WIDTH(TAG_W), .S_TAG_WIDTH(ST_W),
                       .MAX_OUTSTANDING(MAXO)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    dma_desc_arbiter #(.PORTS(3), .PCIE_ADDR_WIDTH(PA_W), .AXI_ADDR_WIDTH(AA_W),
                       .LEN_WIDTH(LEN_W), .TAG_WIDTH(TAG_W), .S_TAG_WIDTH(ST_W),
                       .MAX_OUTSTANDING(16)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [PA_W-1:0] pa, input logic [AA_W-1:0] aa,
                            input logic [LEN_W-1:0] len, input logic [ST_W-1:0] tag, input logic v);
        bus.s_desc_pcie_addr[p*PA_W +: PA_W] = pa;
        bus.s_desc_axi_addr[p*AA_W +: AA_W]  = aa;
        bus.s_desc_len[p*LEN_W +: LEN_W]     = len;
        bus.s_desc_tag[p*ST_W +: ST_W]       = tag;
        bus.s_desc_valid[p]                  = v;
    endtask

    task automatic idle_inputs();
        bus.s_desc_valid    = '0;
        bus.m_desc_ready    = 1'b1;
        bus.s_status_valid  = 1'b0;
        bus.s_status_tag    = '0;
        bus.s_status_error  = '0;
        bus3.s_status_valid = 1'b0;
        bus3.s_status_tag   = '0;
        bus3.s_status_error = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int p = 0; p < int'(PORTS); p++) set_port(p, 64'hFFFF_0000_0000_0000 | 64'(p), 48'h1, 16'd8, 6'(p), 1'b1);
        bus.m_desc_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (bus.m_desc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_desc_valid got=%b exp=0", bus.m_desc_valid); end
        n_checks++; if (bus.m_desc_tag !== 8'h00) begin n_fail++; $display("FAIL reset_m_desc_tag got=%h exp=00", bus.m_desc_tag); end
        n_checks++; if (bus.m_desc_pcie_addr !== 64'h0) begin n_fail++; $display("FAIL reset_m_desc_pcie_addr got=%h exp=0", bus.m_desc_pcie_addr); end
        n_checks++; if (bus.m_desc_len !== 16'h0) begin n_fail++; $display("FAIL reset_m_desc_len got=%h exp=0", bus.m_desc_len); end
        n_checks++; if (bus.m_status_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_m_status_valid got=%b exp=0000", bus.m_status_valid); end
        n_checks++; if (bus.status_unroutable !== 1'b0) begin n_fail++; $display("FAIL reset_unroutable got=%b exp=0", bus.status_unroutable); end
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_single_port();
        do_reset();
        set_port(2, 64'h1234_5678_9ABC_DEF0, 48'h0000_DEAD_BEEF, 16'd64, 6'h05, 1'b1);
        #1;
        n_checks++; if (bus.s_desc_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready got=%b exp=0100", bus.s_desc_ready); end
        tick();
        bus.s_desc_valid = '0;
        n_checks++; if (bus.m_desc_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", bus.m_desc_valid); end
        n_checks++; if (bus.m_desc_tag !== 8'h85) begin n_fail++; $display("FAIL single_tag got=%h exp=85", bus.m_desc_tag); end
        n_checks++; if (bus.m_desc_len !== 16'd64) begin n_fail++; $display("FAIL single_len got=%0d exp=64", bus.m_desc_len); end
        n_checks++; if (bus.m_desc_pcie_addr !== 64'h1234_5678_9ABC_DEF0) begin n_fail++; $display("FAIL single_pcie got=%h exp=123456789abcdef0", bus.m_desc_pcie_addr); end
        n_checks++; if (bus.m_desc_axi_addr !== 48'h0000_DEAD_BEEF) begin n_fail++; $display("FAIL single_axi got=%h exp=0000deadbeef", bus.m_desc_axi_addr); end
        tick();
        n_checks++; if (bus.m_desc_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got=%b exp=0", bus.m_desc_valid); end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_rdy;
        logic [7:0] exp_tag;
        do_reset();
        for (int p = 0; p < int'(PORTS); p++) set_port(p, 64'(p), 48'(p), 16'(p + 1), 6'(16 + p), 1'b1);
        for (int k = 0; k < 8; k++) begin
            exp_rdy = 4'(1 << (k % 4));
            exp_tag = 8'(((k % 4) << ST_W) + 16 + (k % 4));
            #1;
            n_checks++; if (bus.s_desc_ready !== exp_rdy) begin n_fail++; $display("FAIL fair_ready[%0d] got=%b exp=%b", k, bus.s_desc_ready, exp_rdy); end
            tick();
            n_checks++; if (bus.m_desc_valid !== 1'b1 || bus.m_desc_tag !== exp_tag) begin n_fail++; $display("FAIL fair_out[%0d] got=%b/%h exp=1/%h", k, bus.m_desc_valid, bus.m_desc_tag, exp_tag); end
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.m_desc_ready = 1'b0;
        set_port(1, 64'hAAAA_0000_1111_2222, 48'h0000_3333_4444, 16'd100, 6'h2A, 1'b1);
        #1;
        n_checks++; if (bus.s_desc_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_first_ready got=%b exp=0010", bus.s_desc_ready); end
        tick();
        set_port(1, 64'hBBBB, 48'hBB, 16'd7, 6'h11, 1'b1);
        set_port(0, 64'hCCCC, 48'hCC, 16'd9, 6'h22, 1'b1);
        set_port(3, 64'hDDDD, 48'hDD, 16'd3, 6'h33, 1'b1);
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++; if (bus.s_desc_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d] got=%b exp=0000", k, bus.s_desc_ready); end
            tick();
            n_checks++; if (bus.m_desc_valid !== 1'b1 || bus.m_desc_tag !== 8'h6A || bus.m_desc_pcie_addr !== 64'hAAAA_0000_1111_2222 || bus.m_desc_len !== 16'd100)
                begin n_fail++; $display("FAIL bp_hold[%0d] got=%b/%h/%h/%0d exp=1/6a/aaaa000011112222/100", k, bus.m_desc_valid, bus.m_desc_tag, bus.m_desc_pcie_addr, bus.m_desc_len); end
        end
        bus.m_desc_ready = 1'b1;
        #1;
        n_checks++; if (bus.s_desc_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=1000", bus.s_desc_ready); end
        bus.s_desc_valid = '0;
        tick();
        n_checks++; if (bus.m_desc_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%b exp=0", bus.m_desc_valid); end
    endtask

    task automatic test_status_routing();
        do_reset();
        bus.s_status_tag = 8'hC3; bus.s_status_error = 4'h0; bus.s_status_valid = 1'b1;
        bus3.s_status_tag = 8'hC3; bus3.s_status_error = 4'h0; bus3.s_status_valid = 1'b1;
        tick();
        n_checks++; if (bus.m_status_valid !== 4'b1000) begin n_fail++; $display("FAIL st_valid got=%b exp=1000", bus.m_status_valid); end
        n_checks++; if (bus.m_status_tag[3*ST_W +: ST_W] !== 6'h03 || bus.m_status_error[3*ERR_W +: ERR_W] !== 4'h0)
            begin n_fail++; $display("FAIL st_data got=%h/%h exp=03/0", bus.m_status_tag[3*ST_W +: ST_W], bus.m_status_error[3*ERR_W +: ERR_W]); end
        n_checks++; if (bus.status_unroutable !== 1'b0) begin n_fail++; $display("FAIL st_unroutable4 got=%b exp=0", bus.status_unroutable); end
        n_checks++; if (bus3.status_unroutable !== 1'b1 || bus3.m_status_valid !== 3'b000)
            begin n_fail++; $display("FAIL st_unroutable3 got=%b/%b exp=1/000", bus3.status_unroutable, bus3.m_status_valid); end
        bus.s_status_tag = 8'h4A; bus.s_status_error = 4'h5;
        bus3.s_status_tag = 8'h85; bus3.s_status_error = 4'hE;
        tick();
        n_checks++; if (bus.m_status_valid !== 4'b0010 || bus.m_status_tag[ST_W +: ST_W] !== 6'h0A || bus.m_status_error[ERR_W +: ERR_W] !== 4'h5)
            begin n_fail++; $display("FAIL st_b2b_a got=%b/%h/%h exp=0010/0a/5", bus.m_status_valid, bus.m_status_tag[ST_W +: ST_W], bus.m_status_error[ERR_W +: ERR_W]); end
        n_checks++; if (bus3.m_status_valid !== 3'b100 || bus3.status_unroutable !== 1'b0 || bus3.m_status_error[2*ERR_W +: ERR_W] !== 4'hE)
            begin n_fail++; $display("FAIL st_route3 got=%b/%b/%h exp=100/0/e", bus3.m_status_valid, bus3.status_unroutable, bus3.m_status_error[2*ERR_W +: ERR_W]); end
        bus.s_status_tag = 8'h4B; bus.s_status_error = 4'h9;
        bus3.s_status_valid = 1'b0;
        tick();
        n_checks++; if (bus.m_status_valid !== 4'b0010 || bus.m_status_tag[ST_W +: ST_W] !== 6'h0B || bus.m_status_error[ERR_W +: ERR_W] !== 4'h9)
            begin n_fail++; $display("FAIL st_b2b_b got=%b/%h/%h exp=0010/0b/9", bus.m_status_valid, bus.m_status_tag[ST_W +: ST_W], bus.m_status_error[ERR_W +: ERR_W]); end
        bus.s_status_valid = 1'b0;
        tick();
        n_checks++; if (bus.m_status_valid !== 4'b0000 || bus3.m_status_valid !== 3'b000 || bus3.status_unroutable !== 1'b0)
            begin n_fail++; $display("FAIL st_idle got=%b/%b/%b exp=0000/000/0", bus.m_status_valid, bus3.m_status_valid, bus3.status_unroutable); end
    endtask

`ifdef DMA_ARB_LIMIT_EN
    task automatic test_credit();
        do_reset();
        set_port(0, 64'h10, 48'h10, 16'd1, 6'h01, 1'b1);
        #1;
        n_checks++; if (bus.s_desc_ready !== 4'b0001) begin n_fail++; $display("FAIL cred_first got=%b exp=0001", bus.s_desc_ready); end
        tick();
        n_checks++; if (bus.s_desc_ready !== 4'b0001) begin n_fail++; $display("FAIL cred_second got=%b exp=0001", bus.s_desc_ready); end
        tick();
        set_port(1, 64'h20, 48'h20, 16'd2, 6'h02, 1'b1);
        #1;
        n_checks++; if (bus.s_desc_ready !== 4'b0010) begin n_fail++; $display("FAIL cred_block got=%b exp=0010", bus.s_desc_ready); end
        tick();
        n_checks++; if (bus.m_desc_tag !== 8'h42) begin n_fail++; $display("FAIL cred_port1_served got=%h exp=42", bus.m_desc_tag); end
        bus.s_desc_valid[1] = 1'b0;
        bus.s_status_tag = 8'h01; bus.s_status_valid = 1'b1;
        #1;
        n_checks++; if (bus.s_desc_ready !== 4'b0000) begin n_fail++; $display("FAIL cred_still_held got=%b exp=0000", bus.s_desc_ready); end
        tick();
        bus.s_status_valid = 1'b0;
        #1;
        n_checks++; if (bus.s_desc_ready !== 4'b0001) begin n_fail++; $display("FAIL cred_reenable got=%b exp=0001", bus.s_desc_ready); end
        idle_inputs();
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        bus.m_desc_ready = 1'b0;
        set_port(2, 64'h77, 48'h77, 16'd7, 6'h07, 1'b1);
        tick();
        set_port(1, 64'h11, 48'h11, 16'd1, 6'h01, 1'b1);
        set_port(3, 64'h33, 48'h33, 16'd3, 6'h03, 1'b1);
        bus.s_status_tag = 8'h80; bus.s_status_valid = 1'b1;
        rst = 1'b1;
        tick();
        n_checks++; if (bus.m_desc_valid !== 1'b0 || bus.m_desc_tag !== 8'h00 || bus.m_desc_pcie_addr !== 64'h0)
            begin n_fail++; $display("FAIL midrst_slot got=%b/%h/%h exp=0/00/0", bus.m_desc_valid, bus.m_desc_tag, bus.m_desc_pcie_addr); end
        n_checks++; if (bus.m_status_valid !== 4'b0000 || bus.status_unroutable !== 1'b0)
            begin n_fail++; $display("FAIL midrst_status got=%b/%b exp=0000/0", bus.m_status_valid, bus.status_unroutable); end
        rst = 1'b0;
        bus.s_status_valid = 1'b0;
        bus.s_desc_valid[2] = 1'b0;
        bus.m_desc_ready = 1'b1;
        #1;
        n_checks++; if (bus.s_desc_ready !== 4'b0010) begin n_fail++; $display("FAIL midrst_first_grant got=%b exp=0010", bus.s_desc_ready); end
        tick();
        n_checks++; if (bus.m_desc_valid !== 1'b1 || bus.m_desc_tag !== 8'h41) begin n_fail++; $display("FAIL midrst_out got=%b/%h exp=1/41", bus.m_desc_valid, bus.m_desc_tag); end
        idle_inputs();
    endtask

    task automatic test_random();
        int          m_rr;
        bit          m_slot_v;
        desc_t       m_slot;
        desc_t       got;
        int          m_cnt [PORTS];
        logic [3:0]  m_st_v;
        logic [5:0]  m_st_tag;
        logic [3:0]  m_st_err;
        int          m_sp;
        int          g;
        int          p;
        int          sp;
        bit          free;
        bit          acc;
        bit          inc;
        bit          dec;
        logic [3:0]  exp_rdy;
        do_reset();
        m_rr = 0; m_slot_v = 1'b0; m_slot = '0; m_st_v = '0; m_st_tag = '0; m_st_err = '0; m_sp = 0;
        for (int i = 0; i < int'(PORTS); i++) m_cnt[i] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < int'(PORTS); i++)
                set_port(i, {$urandom, $urandom}, 48'({$urandom, $urandom}), 16'($urandom), 6'($urandom),
                         $urandom_range(0, 99) < 60);
            bus.m_desc_ready   = $urandom_range(0, 99) < 70;
            bus.s_status_valid = $urandom_range(0, 99) < 40;
            bus.s_status_tag   = 8'($urandom);
            bus.s_status_error = 4'($urandom);
            #1;
            free = !m_slot_v || bus.m_desc_ready;
            g = -1;
            for (int k = 0; k < int'(PORTS); k++) begin
                p = (m_rr + k) % int'(PORTS);
                if (g < 0 && bus.s_desc_valid[p] && (!LIMIT || m_cnt[p] < MAXO)) g = p;
            end
            acc = (g >= 0) && free;
            exp_rdy = acc ? 4'(1 << g) : 4'b0000;
            n_checks++; if (bus.s_desc_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", cyc, bus.s_desc_ready, exp_rdy); end
            if (acc) begin
                m_slot.pcie_addr = bus.s_desc_pcie_addr[g*PA_W +: PA_W];
                m_slot.axi_addr  = bus.s_desc_axi_addr[g*AA_W +: AA_W];
                m_slot.len       = bus.s_desc_len[g*LEN_W +: LEN_W];
                m_slot.tag       = {2'(g), bus.s_desc_tag[g*ST_W +: ST_W]};
                m_slot_v         = 1'b1;
                m_rr             = (g + 1) % int'(PORTS);
            end else if (bus.m_desc_ready) begin
                m_slot_v = 1'b0;
            end
            sp = int'(bus.s_status_tag >> ST_W);
            m_st_v = '0;
            if (bus.s_status_valid) begin
                m_st_v[sp] = 1'b1;
                m_st_tag   = bus.s_status_tag[5:0];
                m_st_err   = bus.s_status_error;
                m_sp       = sp;
            end
            if (LIMIT) begin
                for (int i = 0; i < int'(PORTS); i++) begin
                    inc = acc && (g == i);
                    dec = bus.s_status_valid && (sp == i);
                    if (inc && !dec) m_cnt[i]++;
                    else if (dec && !inc && m_cnt[i] > 0) m_cnt[i]--;
                end
            end
            tick();
            n_checks++; if (bus.m_desc_valid !== m_slot_v) begin n_fail++; $display("FAIL rnd_desc_valid[%0d] got=%b exp=%b", cyc, bus.m_desc_valid, m_slot_v); end
            if (m_slot_v) begin
                got = {bus.m_desc_pcie_addr, bus.m_desc_axi_addr, bus.m_desc_len, bus.m_desc_tag};
                n_checks++; if (got !== m_slot) begin n_fail++; $display("FAIL rnd_desc_data[%0d] got=%h exp=%h", cyc, got, m_slot); end
            end
            n_checks++; if (bus.m_status_valid !== m_st_v) begin n_fail++; $display("FAIL rnd_st_valid[%0d] got=%b exp=%b", cyc, bus.m_status_valid, m_st_v); end
            if (m_st_v != 4'b0000) begin
                n_checks++; if (bus.m_status_tag[m_sp*ST_W +: ST_W] !== m_st_tag || bus.m_status_error[m_sp*ERR_W +: ERR_W] !== m_st_err)
                    begin n_fail++; $display("FAIL rnd_st_data[%0d] got=%h/%h exp=%h/%h", cyc, bus.m_status_tag[m_sp*ST_W +: ST_W], bus.m_status_error[m_sp*ERR_W +: ERR_W], m_st_tag, m_st_err); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        bus.s_desc_pcie_addr  = '0;
        bus.s_desc_axi_addr   = '0;
        bus.s_desc_len        = '0;
        bus.s_desc_tag        = '0;
        bus3.s_desc_pcie_addr = '0;
        bus3.s_desc_axi_addr  = '0;
        bus3.s_desc_len       = '0;
        bus3.s_desc_tag       = '0;
        bus3.s_desc_valid     = '0;
        bus3.m_desc_ready     = 1'b1;
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_single_port();
        test_fairness();
        test_backpressure();
        test_status_routing();
`ifdef DMA_ARB_LIMIT_EN
        test_credit();
`endif
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
